// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 raster timing from a 50 MHz clock.
// A divide-by-2 toggle paces the counters; sync/blank are registered from next-state coordinates.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       VGA_CLK,
    output logic       pix_en,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       tog_q;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, fs_q, fs_d;
    logic       x_wrap, y_wrap;

    always_comb begin
        x_wrap    = tog_q && (x_q == H_LAST);
        y_wrap    = x_wrap && (y_q == V_LAST);
        x_d       = tog_q ? (x_wrap ? '0 : x_q + 10'd1) : x_q;
        y_d       = x_wrap ? (y_wrap ? '0 : y_q + 10'd1) : y_q;
        hs_d      = !(x_d >= HS_BEG && x_d < HS_END);
        vs_d      = !(y_d >= VS_BEG && y_d < VS_END);
        blank_n_d = (x_d < H_VIS) && (y_d < V_VIS);
        fs_d      = y_wrap;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tog_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            tog_q     <= ~tog_q;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fs_q      <= fs_d;
        end
    end

    // VGA_CLK falls on the edge where the counters move, giving a full Clk of setup before it rises
    assign VGA_CLK     = tog_q;
    assign pix_en      = tog_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed checks of vga_scan_gen; default timing for line behaviour,
// a shrunken 16x12 raster for vertical, frame-wrap and mid-frame reset behaviour.
module tb_vga_scan_gen;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    logic       d_clk, d_pe, d_hs, d_vs, d_bl, d_sn, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_clk, s_pe, s_hs, s_vs, s_bl, s_sn, s_fs;
    logic [9:0] s_x, s_y;
    logic       p_hs, p_vs;
    logic [9:0] p_x;

    always #10 Clk = ~Clk;

    vga_scan_gen u_d (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(d_clk), .pix_en(d_pe), .VGA_HS(d_hs),
        .VGA_VS(d_vs), .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sn), .DrawX(d_x), .DrawY(d_y),
        .frame_start(d_fs)
    );

    // small raster: H_TOTAL 16 (HS on 10..12), V_TOTAL 12 (VS on 8..9), frame 384 Clk
    vga_scan_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_s (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(s_clk), .pix_en(s_pe), .VGA_HS(s_hs),
        .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn), .DrawX(s_x), .DrawY(s_y),
        .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_xy(input bit sm, input int xt, input int yt, input int max, input string tag);
        int n = 0;
        while (!((sm ? s_x : d_x) == 10'(xt) && (sm ? s_y : d_y) == 10'(yt)) && n < max) begin
            @(negedge Clk);
            n++;
        end
        chk(tag, {31'b0, (sm ? s_x : d_x) == 10'(xt) && (sm ? s_y : d_y) == 10'(yt)}, 1);
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_pe"}, s_pe, 0);
        chk({tag, "_clk"}, s_clk, 0);
        chk({tag, "_x"}, s_x, 0);
        chk({tag, "_y"}, s_y, 0);
        chk({tag, "_hs"}, s_hs, 1);
        chk({tag, "_vs"}, s_vs, 1);
        chk({tag, "_blank"}, s_bl, 1);
        chk({tag, "_fs"}, s_fs, 0);
    endtask

    // invariants sampled every falling Clk: bounds, SYNC_N, blank region, no change within a pixel
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("d_x_range", {31'b0, d_x < 10'd800}, 1);
            chk("d_y_range", {31'b0, d_y < 10'd525}, 1);
            chk("d_sync_n", d_sn, 0);
            chk("s_sync_n", s_sn, 0);
            chk("s_x_range", {31'b0, s_x < 10'd16}, 1);
            chk("s_y_range", {31'b0, s_y < 10'd12}, 1);
            chk("s_blank_region", s_bl, {31'b0, s_x < 10'd8 && s_y < 10'd6});
            if (s_clk) begin
                chk("s_hs_stable", s_hs, p_hs);
                chk("s_vs_stable", s_vs, p_vs);
                chk("s_x_stable", s_x, p_x);
            end
        end
        p_hs <= s_hs;
        p_vs <= s_vs;
        p_x  <= s_x;
    end

    initial begin
        int n, lo, first, last, fs_cnt;
        repeat (5) @(negedge Clk);
        chk("rst_pe", d_pe, 0);
        chk("rst_clk", d_clk, 0);
        chk("rst_x", d_x, 0);
        chk("rst_y", d_y, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_blank", d_bl, 1);
        chk("rst_sync_n", d_sn, 0);
        chk("rst_fs", d_fs, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("e1_pe", d_pe, 1);
        chk("e1_vgaclk", d_clk, 1);
        chk("e1_x", d_x, 0);
        chk("e1_fs", d_fs, 0);
        @(negedge Clk);
        chk("e2_pe", d_pe, 0);
        chk("e2_x", d_x, 1);
        @(negedge Clk);
        chk("e3_pe", d_pe, 1);
        chk("e3_x", d_x, 1);
        @(negedge Clk);
        chk("e4_pe", d_pe, 0);
        chk("e4_x", d_x, 2);

        wait_xy(0, 639, 0, 2000, "reach_639");
        chk("blank_639", d_bl, 1);
        repeat (2) @(negedge Clk);
        chk("x_640", d_x, 640);
        chk("blank_640", d_bl, 0);
        chk("hs_640", d_hs, 1);
        n = 0; lo = 0; first = -1; last = -1;
        while (d_x != 10'd799 && n < 400) begin
            @(negedge Clk);
            n++;
            if (!d_hs) begin
                lo++;
                if (first < 0) first = int'(d_x);
                last = int'(d_x);
            end
        end
        chk("hs_low_clks", lo, 192);
        chk("hs_first_x", first, 656);
        chk("hs_last_x", last, 751);
        chk("hs_799", d_hs, 1);
        chk("y_at_799", d_y, 0);
        repeat (2) @(negedge Clk);
        chk("wrap_x", d_x, 0);
        chk("wrap_y", d_y, 1);
        chk("wrap_blank", d_bl, 1);
        chk("wrap_fs", d_fs, 0);

        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wait_xy(1, 15, 7, 600, "s_reach_15_7");
        chk("s_vs_line7", s_vs, 1);
        repeat (2) @(negedge Clk);
        chk("s_y8_x", s_x, 0);
        chk("s_vs_line8", s_vs, 0);
        chk("s_blank_line8", s_bl, 0);
        n = 0;
        while (!s_vs && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("s_vs_low_clks", n, 64);
        chk("s_vs_end_x", s_x, 0);
        chk("s_vs_end_y", s_y, 10);

        wait_xy(1, 15, 11, 200, "s_reach_15_11");
        chk("s_fs_before_wrap", s_fs, 0);
        repeat (2) @(negedge Clk);
        chk("s_frame_x", s_x, 0);
        chk("s_frame_y", s_y, 0);
        chk("s_frame_fs", s_fs, 1);
        chk("s_frame_blank", s_bl, 1);
        @(negedge Clk);
        chk("s_fs_one_clk", s_fs, 0);
        n = 1;
        while (!s_fs && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk("s_frame_period", n, 384);

        wait_xy(1, 11, 3, 400, "s_reach_11_3");
        chk("s_hs_mid", s_hs, 0);
        chk("s_blank_mid", s_bl, 0);
        #5 Reset_n = 1'b0;
        #1 chk_reset_s("async_rst");
        chk("async_rst_d_x", d_x, 0);
        @(negedge Clk);
        chk_reset_s("held_rst");
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rel_e1_pe", s_pe, 1);
        chk("rel_e1_x", s_x, 0);
        chk("rel_e1_y", s_y, 0);
        chk("rel_e1_fs", s_fs, 0);
        @(negedge Clk);
        chk("rel_e2_x", s_x, 1);
        chk("rel_e2_fs", s_fs, 0);
        fs_cnt = 0;
        repeat (1158) begin
            @(negedge Clk);
            if (s_fs) fs_cnt++;
        end
        chk("s_fs_three_frames", fs_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
